// File: rtl/tls_pkg.sv
// Shared types for the multi-phase traffic-light controller:
// lamp state encoding and the duration-extract helper.
package tls_pkg;

  localparam int unsigned ST_W  = 2;
  localparam int unsigned BUS_W = 256;

  typedef enum logic [ST_W-1:0] {
    ST_GREEN  = 2'd0,
    ST_YELLOW = 2'd1,
    ST_ALLRED = 2'd2
  } tls_state_e;

  // Pull field idx of width cw out of a packed bus.
  // A zero duration is treated as one cycle.
  function automatic logic [31:0] dur_pick(
    input logic [BUS_W-1:0] bus,
    input int unsigned      idx,
    input int unsigned      cw
  );
    logic [31:0] v;
    logic [31:0] m;
    v = 32'(bus >> (idx * cw));
    m = (cw >= 32) ? '1 : ((32'd1 << cw) - 32'd1);
    v = v & m;
    return (v == '0) ? 32'd1 : v;
  endfunction

endpackage

// File: rtl/tls_phase_sel.sv
// Next-phase selector: cyclic search for demand after phase.
// Ports: phase, req, mode in; nxt out (next phase index).
module tls_phase_sel #(
  parameter int NPH = 2,
  parameter int PW  = $clog2(NPH)
) (
  input  logic [PW-1:0]  phase,
  input  logic [NPH-1:0] req,
  input  logic           mode,
  output logic [PW-1:0]  nxt
);

  logic          found;
  int            j;
  logic [PW-1:0] sel;

  // Current phase is visited last (i == NPH) so a lone
  // request on it re-greens the same phase.
  always_comb begin
    found = 1'b0;
    j     = 0;
    sel   = '0;
    nxt   = PW'((int'(phase) + 1) % NPH);
    if (mode) begin
      for (int i = 1; i <= NPH; i++) begin
        j   = (int'(phase) + i) % NPH;
        sel = PW'(j);
        if (!found && req[sel]) begin
          nxt   = sel;
          found = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/tls_multi_phase.sv
// NPH-phase traffic-light Moore FSM with all-red clearance.
// Ports: clk, reset, Set/Stop/Jump/Mode, Req, Gin/Yin/Ain in;
// Gout/Yout/Rout lamps and Phase index out.
module tls_multi_phase
  import tls_pkg::*;
#(
  parameter int NPH = 2,
  parameter int CW  = 4,
  parameter int PW  = $clog2(NPH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Set,
  input  logic              Stop,
  input  logic              Jump,
  input  logic              Mode,
  input  logic [NPH-1:0]    Req,
  input  logic [NPH*CW-1:0] Gin,
  input  logic [NPH*CW-1:0] Yin,
  input  logic [CW-1:0]     Ain,
  output logic [NPH-1:0]    Gout,
  output logic [NPH-1:0]    Yout,
  output logic [NPH-1:0]    Rout,
  output logic [PW-1:0]     Phase
);

  tls_state_e        state_q, state_d;
  logic [PW-1:0]     phase_q, phase_d;
  logic [PW-1:0]     phase_nxt;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [NPH*CW-1:0] g_q, y_q;
  logic [CW-1:0]     a_q;
  logic [31:0]       cur_dur;
  logic              done;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NPH; k++) begin
        g_q[k*CW +: CW] <= CW'(1);
        y_q[k*CW +: CW] <= CW'(1);
      end
      a_q <= CW'(1);
    end else if (Set) begin
      g_q <= Gin;
      y_q <= Yin;
      a_q <= Ain;
    end
  end

  tls_phase_sel #(
    .NPH (NPH),
    .PW  (PW)
  ) u_sel (
    .phase (phase_q),
    .req   (Req),
    .mode  (Mode),
    .nxt   (phase_nxt)
  );

  always_comb begin
    cur_dur = 32'd1;
    unique case (state_q)
      ST_GREEN:
        cur_dur = dur_pick(BUS_W'(g_q),
                           32'(phase_q), CW);
      ST_YELLOW:
        cur_dur = dur_pick(BUS_W'(y_q),
                           32'(phase_q), CW);
      ST_ALLRED:
        cur_dur = dur_pick(BUS_W'(a_q), 0, CW);
      default:
        cur_dur = 32'd1;
    endcase
  end

  assign done = (32'(cnt_q) == cur_dur);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_GREEN;
      phase_q <= '0;
      cnt_q   <= CW'(1);
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    if (Set) begin
      state_d = ST_GREEN;
      phase_d = '0;
      cnt_d   = CW'(1);
    end else if (Stop) begin
      state_d = state_q;
    end else if (Jump && state_q == ST_GREEN) begin
      state_d = ST_YELLOW;
      cnt_d   = CW'(1);
    end else if (done) begin
      cnt_d = CW'(1);
      unique case (state_q)
        ST_GREEN:  state_d = ST_YELLOW;
        ST_YELLOW: state_d = ST_ALLRED;
        ST_ALLRED: begin
          state_d = ST_GREEN;
          phase_d = phase_nxt;
        end
        default:   state_d = ST_GREEN;
      endcase
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_comb begin
    Gout = '0;
    Yout = '0;
    Rout = '1;
    unique case (1'b1)
      (state_q == ST_GREEN): begin
        Gout[phase_q] = 1'b1;
        Rout[phase_q] = 1'b0;
      end
      (state_q == ST_YELLOW): begin
        Yout[phase_q] = 1'b1;
        Rout[phase_q] = 1'b0;
      end
      default: Rout = '1;
    endcase
  end

  assign Phase = phase_q;

endmodule

// File: tb/tb_tls_multi_phase.sv
// Bench for tls_multi_phase: NPH=2 vector table plus
// NPH=4 actuated-mode sequences, scoreboard-checked.
module tb_tls_multi_phase;

  localparam int SG = 0;
  localparam int SY = 1;
  localparam int SA = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_rst = 1'b1, a_set = 1'b0, a_stop = 1'b0;
  logic       a_jump = 1'b0, a_mode = 1'b0;
  logic [1:0] a_req = '0;
  logic [7:0] a_gin = '0, a_yin = '0;
  logic [3:0] a_ain = '0;
  logic [1:0] a_g, a_y, a_r;
  logic [0:0] a_ph;

  logic        b_rst = 1'b1, b_set = 1'b0, b_stop = 1'b0;
  logic        b_jump = 1'b0, b_mode = 1'b0;
  logic [3:0]  b_req = '0;
  logic [15:0] b_gin = '0, b_yin = '0;
  logic [3:0]  b_ain = '0;
  logic [3:0]  b_g, b_y, b_r;
  logic [1:0]  b_ph;

  tls_multi_phase #(.NPH(2), .CW(4)) dut_a (
    .clk (clk), .reset (a_rst), .Set (a_set),
    .Stop (a_stop), .Jump (a_jump), .Mode (a_mode),
    .Req (a_req), .Gin (a_gin), .Yin (a_yin),
    .Ain (a_ain), .Gout (a_g), .Yout (a_y),
    .Rout (a_r), .Phase (a_ph)
  );

  tls_multi_phase #(.NPH(4), .CW(4)) dut_b (
    .clk (clk), .reset (b_rst), .Set (b_set),
    .Stop (b_stop), .Jump (b_jump), .Mode (b_mode),
    .Req (b_req), .Gin (b_gin), .Yin (b_yin),
    .Ain (b_ain), .Gout (b_g), .Yout (b_y),
    .Rout (b_r), .Phase (b_ph)
  );

  typedef struct {
    int dut;
    int st;
    int ph;
  } exp_t;

  typedef struct {
    logic       rst, set, stop, jump;
    logic [7:0] gin, yin;
    logic [3:0] ain;
    int         st;
    int         ph;
  } vec_t;

  exp_t sbq[$];
  vec_t tv[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check_pop(input string tag);
    exp_t       e;
    logic [7:0] eg, ey, er, ag, ay, ar, mask;
    int         aph, n;
    n_cmp++;
    if (sbq.size() == 0) begin
      n_bad++;
      $display("FAIL %s: scoreboard empty", tag);
      return;
    end
    e    = sbq.pop_front();
    n    = (e.dut == 0) ? 2 : 4;
    mask = 8'((1 << n) - 1);
    eg   = (e.st == SG) ? 8'(1 << e.ph) : 8'h00;
    ey   = (e.st == SY) ? 8'(1 << e.ph) : 8'h00;
    er   = ~(eg | ey) & mask;
    if (e.dut == 0) begin
      ag = 8'(a_g); ay = 8'(a_y); ar = 8'(a_r);
      aph = int'(a_ph);
    end else begin
      ag = 8'(b_g); ay = 8'(b_y); ar = 8'(b_r);
      aph = int'(b_ph);
    end
    if ({ag, ay, ar} !== {eg, ey, er} || aph != e.ph) begin
      n_bad++;
      $display("FAIL %s: got G=%b Y=%b R=%b ph=%0d want G=%b Y=%b R=%b ph=%0d",
               tag, ag, ay, ar, aph, eg, ey, er, e.ph);
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    #1;
    check_pop(tag);
  endtask

  task automatic add(input logic rst, input logic set,
                     input logic stop, input logic jump,
                     input logic [7:0] gin,
                     input logic [7:0] yin,
                     input logic [3:0] ain,
                     input int st, input int ph);
    vec_t v;
    v.rst = rst; v.set = set; v.stop = stop;
    v.jump = jump; v.gin = gin; v.yin = yin;
    v.ain = ain; v.st = st; v.ph = ph;
    tv.push_back(v);
  endtask

  task automatic rep(input int cnt, input int st,
                     input int ph);
    for (int i = 0; i < cnt; i++)
      add(0, 0, 0, 0, 0, 0, 0, st, ph);
  endtask

  task automatic bstep(input logic rst, input logic mode,
                       input logic [3:0] req,
                       input int st, input int ph,
                       input string tag);
    exp_t e;
    b_rst = rst; b_mode = mode; b_req = req;
    e.dut = 1; e.st = st; e.ph = ph;
    sbq.push_back(e);
    tick(tag);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit hit");
    $fatal(1, "time limit");
  end

  initial begin
    exp_t e;
    // reset, all durations 1: period 6
    add(1, 0, 0, 0, 0, 0, 0, SG, 0);
    rep(1, SY, 0); rep(1, SA, 0); rep(1, SG, 1);
    rep(1, SY, 1); rep(1, SA, 1); rep(1, SG, 0);
    rep(1, SY, 0);
    // G={3,5} Y={2,2} A=1: period 14
    add(0, 1, 0, 0, 8'h53, 8'h22, 4'd1, SG, 0);
    rep(2, SG, 0); rep(2, SY, 0); rep(1, SA, 0);
    rep(5, SG, 1); rep(2, SY, 1); rep(1, SA, 1);
    rep(1, SG, 0);
    // jump on 2nd green cycle, then during all-red
    rep(1, SG, 0);
    add(0, 0, 0, 1, 0, 0, 0, SY, 0);
    rep(1, SY, 0); rep(1, SA, 0);
    add(0, 0, 0, 1, 0, 0, 0, SG, 1);
    // stop held 4 cycles in yellow
    rep(4, SG, 1); rep(1, SY, 1);
    for (int i = 0; i < 4; i++)
      add(0, 0, 1, 0, 0, 0, 0, SY, 1);
    rep(1, SY, 1); rep(1, SA, 1); rep(1, SG, 0);
    // set during stop, A=3; jump in yellow/all-red ignored
    rep(2, SG, 0); rep(1, SY, 0);
    add(0, 1, 1, 0, 8'h53, 8'h22, 4'd3, SG, 0);
    add(0, 0, 1, 0, 0, 0, 0, SG, 0);
    rep(2, SG, 0); rep(1, SY, 0);
    add(0, 0, 0, 1, 0, 0, 0, SY, 0);
    rep(1, SA, 0);
    add(0, 0, 0, 1, 0, 0, 0, SA, 0);
    add(0, 0, 0, 1, 0, 0, 0, SA, 0);
    rep(1, SG, 1);
    // zero durations act as 1
    add(0, 1, 0, 0, 8'h00, 8'h00, 4'd0, SG, 0);
    rep(1, SY, 0); rep(1, SA, 0); rep(1, SG, 1);
    rep(1, SY, 1); rep(1, SA, 1); rep(1, SG, 0);
    // reset mid all-red restores unit durations
    add(0, 1, 0, 0, 8'h53, 8'h22, 4'd3, SG, 0);
    rep(2, SG, 0); rep(2, SY, 0); rep(1, SA, 0);
    add(1, 0, 0, 0, 0, 0, 0, SG, 0);
    rep(1, SY, 0); rep(1, SA, 0); rep(1, SG, 1);

    foreach (tv[i]) begin
      a_rst  = tv[i].rst;
      a_set  = tv[i].set;
      a_stop = tv[i].stop;
      a_jump = tv[i].jump;
      a_gin  = tv[i].gin;
      a_yin  = tv[i].yin;
      a_ain  = tv[i].ain;
      e.dut = 0; e.st = tv[i].st; e.ph = tv[i].ph;
      sbq.push_back(e);
      tick($sformatf("A%0d", i));
    end
    a_set = 1'b0; a_stop = 1'b0; a_jump = 1'b0;

    // NPH=4 actuated: Req=0100 from phase 0 -> phase 2
    bstep(1, 1, 4'b0100, SG, 0, "b_rst1");
    bstep(0, 1, 4'b0100, SY, 0, "b_y0a");
    bstep(0, 1, 4'b0100, SA, 0, "b_a0a");
    bstep(0, 1, 4'b0100, SG, 2, "b_req0100");
    // no demand -> phase 1
    bstep(1, 1, 4'b0000, SG, 0, "b_rst2");
    bstep(0, 1, 4'b0000, SY, 0, "b_y0b");
    bstep(0, 1, 4'b0000, SA, 0, "b_a0b");
    bstep(0, 1, 4'b0000, SG, 1, "b_req0000");
    // demand only on current phase -> re-green 0
    bstep(1, 1, 4'b0001, SG, 0, "b_rst3");
    bstep(0, 1, 4'b0001, SY, 0, "b_y0c");
    bstep(0, 1, 4'b0001, SA, 0, "b_a0c");
    bstep(0, 1, 4'b0001, SG, 0, "b_req0001");
    // Req=0011: 0 -> 1, then wrap 1 -> 0
    bstep(0, 1, 4'b0011, SY, 0, "b_y0d");
    bstep(0, 1, 4'b0011, SA, 0, "b_a0d");
    bstep(0, 1, 4'b0011, SG, 1, "b_req0011_1");
    bstep(0, 1, 4'b0011, SY, 1, "b_y1");
    bstep(0, 1, 4'b0011, SA, 1, "b_a1");
    bstep(0, 1, 4'b0011, SG, 0, "b_wrap0");
    // fixed mode ignores Req
    bstep(0, 0, 4'b1000, SY, 0, "b_y0e");
    bstep(0, 0, 4'b1000, SA, 0, "b_a0e");
    bstep(0, 0, 4'b1000, SG, 1, "b_fixed");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
